// File: rtl/aes_enc_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES encipher core.
// Round-count constants, FSM encoding, and the byte-level transforms used by the datapath.
package aes_enc_pkg;

  typedef enum logic [1:0] {
    KEYLEN_128  = 2'b00,
    KEYLEN_192  = 2'b01,
    KEYLEN_256  = 2'b10,
    KEYLEN_RSVD = 2'b11
  } keylen_e;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Reserved key length falls back to the AES-128 schedule.
  function automatic int nr_of(input logic [1:0] kl);
    case (keylen_e'(kl))
      KEYLEN_192: return NR_192;
      KEYLEN_256: return NR_256;
      default:    return NR_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // Byte r+4c holds row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// 128-bit SubBytes: NUM_LANES independent byte S-boxes computed as GF inverse plus affine map.
module aes_sbox
  import aes_enc_pkg::*;
#(
  parameter int NUM_LANES = 16
) (
  input  logic [NUM_LANES*8-1:0] sboxw,
  output logic [NUM_LANES*8-1:0] new_sboxw
);

  logic [NUM_LANES-1:0][7:0] lane_in;
  logic [NUM_LANES-1:0][7:0] lane_out;

  assign lane_in   = sboxw;
  assign new_sboxw = lane_out;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_out[i] = sbox_byte(lane_in[i]);
  end

endmodule

// File: rtl/aes_encipher_mk.sv
// Iterative AES-128/192/256 encipher, one round per clock, with an internal round-key memory.
// Define AES_ENC_PERF_CNT_EN to add the blk_count / stall_cycles performance counters.
module aes_encipher_mk
  import aes_enc_pkg::*;
#(
  parameter int MAX_ROUNDS = 14,
  parameter int KEY_AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rk_wr_en,
  input  logic [KEY_AW-1:0] rk_wr_addr,
  input  logic [127:0]      rk_wr_data,
  output logic              rk_wr_ready,
  input  logic [1:0]        keylen,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block,
  output logic              busy
`ifdef AES_ENC_PERF_CNT_EN
  ,
  output logic [31:0]       blk_count,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [KEY_AW-1:0] MAX_R = KEY_AW'(MAX_ROUNDS);

  state_e            state;
  logic [KEY_AW-1:0] round;
  logic [KEY_AW-1:0] nr;
  logic [KEY_AW-1:0] nr_sel;
  logic [127:0]      blk;
  logic [127:0]      sb;
  logic [127:0]      sr;
  logic [127:0]      rk_cur;
  logic [127:0]      rk [0:MAX_ROUNDS];

  assign in_ready    = (state == ST_IDLE);
  assign rk_wr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  always_comb begin
    nr_sel = KEY_AW'(nr_of(keylen));
    if (nr_of(keylen) > MAX_ROUNDS) nr_sel = MAX_R;
  end

  // Key memory is deliberately not reset; keys survive an aborting reset.
  always_ff @(posedge clk) begin
    if (rk_wr_en && rk_wr_ready && (rk_wr_addr <= MAX_R))
      rk[rk_wr_addr] <= rk_wr_data;
  end

  aes_sbox #(.NUM_LANES(16)) u_sbox (
    .sboxw    (blk),
    .new_sboxw(sb)
  );

  assign sr     = shiftrows(sb);
  assign rk_cur = rk[round];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      round     <= '0;
      nr        <= '0;
      blk       <= '0;
      out_valid <= 1'b0;
      out_block <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // rk[0] is read before any same-cycle key write lands.
          if (in_valid) begin
            blk   <= in_block ^ rk[0];
            nr    <= nr_sel;
            round <= KEY_AW'(1);
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (round == nr) begin
            out_block <= sr ^ rk_cur;
            out_valid <= 1'b1;
            round     <= '0;
            state     <= ST_DONE;
          end else begin
            blk   <= mixcolumns(sr) ^ rk_cur;
            round <= round + KEY_AW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_ENC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (out_valid && out_ready)  blk_count    <= blk_count + 32'd1;
      if (out_valid && !out_ready) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_encipher_mk.sv
// Scoreboard bench for aes_encipher_mk: textbook AES reference model, FIPS-197 vectors, random traffic.
`timescale 1ns/1ps
module tb_aes_encipher_mk;
  localparam int KEY_AW = 4;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] KAT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 0, rst = 0;
  logic rk_wr_en = 0, rk_wr_ready;
  logic [KEY_AW-1:0] rk_wr_addr = '0;
  logic [127:0] rk_wr_data = '0;
  logic [1:0] keylen = '0;
  logic in_valid = 0, in_ready;
  logic [127:0] in_block = '0;
  logic out_valid, out_ready = 1;
  logic [127:0] out_block;
  logic busy;
`ifdef AES_ENC_PERF_CNT_EN
  logic [31:0] blk_count, stall_cycles;
  int exp_blk = 0, exp_stall = 0;
`endif

  aes_encipher_mk #(.MAX_ROUNDS(14), .KEY_AW(KEY_AW)) dut (
    .clk(clk), .rst(rst),
    .rk_wr_en(rk_wr_en), .rk_wr_addr(rk_wr_addr), .rk_wr_data(rk_wr_data), .rk_wr_ready(rk_wr_ready),
    .keylen(keylen), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
`ifdef AES_ENC_PERF_CNT_EN
    , .blk_count(blk_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] data; int acc; int nr; } exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] sbox_t [256];
  logic [127:0] mk [0:14];
  int stall_req = 0;
  bit rand_bp = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic int model_nr(logic [1:0] kl);
    return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Textbook cipher over a byte array using the current model round keys.
  function automatic logic [127:0] model_enc(logic [127:0] pt, int nr);
    logic [7:0] s[16], t[16], a[4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ mk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (r != nr)
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          for (int w = 0; w < 4; w++)
            s[4*c+w] = gmul(a[w], 8'h02) ^ gmul(a[(w+1)%4], 8'h03) ^ a[(w+2)%4] ^ a[(w+3)%4];
        end
      for (int i = 0; i < 16; i++) s[i] ^= mk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic wr_key(input logic [KEY_AW-1:0] a, input logic [127:0] d);
    bit got = 0;
    rk_wr_en = 1; rk_wr_addr = a; rk_wr_data = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rk_wr_ready) begin got = 1; break; end
    end
    if (!got) chk("wr_key_timeout", 128'(rk_wr_ready), 128'(1));
    @(posedge clk); #1;
    rk_wr_en = 0;
    if (got && a <= 14) mk[a] = d;
  endtask

  task automatic load_keys(input logic [255:0] key, input logic [1:0] kl);
    int nk = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
    int nr = model_nr(kl);
    logic [31:0] w[60];
    logic [31:0] tmp;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k <= nr; k++) wr_key(KEY_AW'(k), {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]});
  endtask

  task automatic send(input logic [127:0] pt, input logic [1:0] kl, input logic [127:0] expv, input bit use_model);
    bit got = 0;
    exp_t e;
    in_block = pt; keylen = kl; in_valid = 1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 128'(in_ready), 128'(1));
    else begin
      e.data = use_model ? model_enc(pt, model_nr(kl)) : expv;
      e.acc = cyc + 1;
      e.nr = model_nr(kl);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    keylen = 2'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 128'(sbq.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (stall_req > 0 && out_valid) begin out_ready = 0; stall_req--; end
    else out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: latency, stability under backpressure, ciphertext on each handshake.
  bit prev_v = 0, prev_r = 0, after_hs = 0;
  logic [127:0] prev_b;
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 0; after_hs = 0;
`ifdef AES_ENC_PERF_CNT_EN
      exp_blk = 0; exp_stall = 0;
`endif
    end else begin
      if (after_hs) chk("in_ready_after_handshake", 128'(in_ready), 128'(1));
      after_hs = 0;
      if (out_valid) begin
        chk("in_ready_low_while_valid", 128'(in_ready), 128'(0));
        if (!prev_v) begin
          if (sbq.size() == 0) chk("unexpected_output", 128'(out_valid), 128'(0));
          else chk("latency", 128'(cyc - sbq[0].acc), 128'(sbq[0].nr));
        end else if (!prev_r) chk("out_block_stable", out_block, prev_b);
        if (out_ready) begin
          if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("ciphertext", out_block, me.data);
          end
          after_hs = 1;
`ifdef AES_ENC_PERF_CNT_EN
          exp_blk++;
        end else begin
          exp_stall++;
`endif
        end
      end
      prev_v = out_valid; prev_r = out_ready; prev_b = out_block;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p, q, t, x;
    logic [127:0] new0, pt;
    logic [255:0] key;
    logic [1:0] kl;
    p = 1; q = 1;
    do begin
      t = p; p = t ^ {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0}; q = q ^ {q[5:0], 2'b0}; q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 1);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 15; i++) mk[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_block", out_block, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'({in_ready, rk_wr_ready}), 128'(2'b11));
    @(posedge clk); #1 rst = 1;

    // Known-answer vectors, AES-256 under a 20-cycle output stall
    load_keys(KEY128, 2'b00); send(PT, 2'b00, KAT128, 0); wait_idle();
    load_keys(KEY192, 2'b01); send(PT, 2'b01, KAT192, 0); wait_idle();
    load_keys(KEY256, 2'b10); stall_req = 20; send(PT, 2'b10, KAT256, 0); wait_idle();

    // Key write while busy is dropped; out-of-range address is ignored
    load_keys(KEY128, 2'b00);
    send({$urandom, $urandom, $urandom, $urandom}, 2'b00, '0, 1);
    rk_wr_en = 1; rk_wr_addr = 4'd3; rk_wr_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin @(negedge clk); chk("rk_wr_ready_busy", 128'(rk_wr_ready), 128'(0)); end
    @(posedge clk); #1 rk_wr_en = 0;
    wait_idle();
    wr_key(4'd15, {$urandom, $urandom, $urandom, $urandom});
    send(PT, 2'b00, KAT128, 0);
    send(PT, 2'b11, KAT128, 0);
    wait_idle();

    // Reset mid-encryption aborts without output; keys retained
    send({$urandom, $urandom, $urandom, $urandom}, 2'b00, '0, 1);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    void'(sbq.pop_back());
    @(negedge clk);
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    send(PT, 2'b00, KAT128, 0);
    wait_idle();

    // Key write to rk[0] in the accepting cycle: block sees the old key
    new0 = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom, $urandom, $urandom};
    rk_wr_en = 1; rk_wr_addr = '0; rk_wr_data = new0;
    in_valid = 1; in_block = pt; keylen = 2'b00;
    @(negedge clk);
    chk("simul_ready", 128'({in_ready, rk_wr_ready}), 128'(2'b11));
    sbq.push_back('{data: model_enc(pt, 10), acc: cyc + 1, nr: 10});
    @(posedge clk); #1;
    rk_wr_en = 0; in_valid = 0;
    mk[0] = new0;
    send({$urandom, $urandom, $urandom, $urandom}, 2'b00, '0, 1);
    wait_idle();

    // Randomized keys, key lengths, plaintexts and backpressure
    rand_bp = 1;
    for (int it = 0; it < 20; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl = 2'($urandom_range(0, 3));
      load_keys(key, kl);
      for (int b = 0; b < int'($urandom_range(1, 3)); b++)
        send({$urandom, $urandom, $urandom, $urandom}, kl, '0, 1);
    end
    wait_idle();
    rand_bp = 0;
    wait_idle();

`ifdef AES_ENC_PERF_CNT_EN
    rst = 0; @(posedge clk); #1 rst = 1;
    load_keys(KEY128, 2'b00);
    for (int b = 0; b < 3; b++) begin stall_req = 4; send(PT, 2'b00, KAT128, 0); wait_idle(); end
    @(negedge clk);
    chk("perf_blk_count", 128'(blk_count), 128'(3));
    chk("perf_stall_cycles", 128'(stall_cycles), 128'(12));
    chk("perf_stall_model", 128'(stall_cycles), 128'(exp_stall));
    @(posedge clk); #1;
    force dut.blk_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.blk_count;
    send(PT, 2'b00, KAT128, 0);
    wait_idle();
    @(negedge clk);
    chk("perf_blk_wrap", 128'(blk_count), 128'(0));
    @(posedge clk); #1;
`endif

    chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
